// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver with glitch filter, frame checker and scan-code FIFO
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] key_reg,
    output logic       key_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FW-1:0] r_filt_cnt;
    logic          r_clk_filt, r_clk_filt_d;
    logic [1:0]    r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_parity_err, r_frame_err, r_overflow;

    logic w_fall, w_timeout, w_stop_ev, w_par_ok, w_push;
    logic w_full, w_empty, w_pop, w_wr;
    logic w_perr_set, w_ferr_set, w_ovf_set;

    // Bus idles high, so synchronizers come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_fall     = r_clk_filt_d & ~r_clk_filt;
    assign w_timeout  = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_stop_ev  = w_fall && (r_state == S_STOP);
    assign w_par_ok   = ^{r_shift, r_par};
    assign w_push     = w_stop_ev && w_par_ok && r_dat_s2;
    assign w_perr_set = w_stop_ev && !w_par_ok;
    assign w_ferr_set = (w_stop_ev && w_par_ok && !r_dat_s2) || w_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            if (r_state == S_IDLE || w_fall || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TW'(1);

            if (w_timeout) begin
                r_state <= S_IDLE;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_perr_set)   r_parity_err <= 1'b1;
            else if (clr_err) r_parity_err <= 1'b0;
            if (w_ferr_set)   r_frame_err  <= 1'b1;
            else if (clr_err) r_frame_err  <= 1'b0;
            if (w_ovf_set)    r_overflow   <= 1'b1;
            else if (clr_err) r_overflow   <= 1'b0;
        end
    end

    assign key_valid  = !w_empty;
    assign key_reg    = w_empty ? 8'h00 : r_mem[r_rptr];
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
    localparam int DEPTH = 4;
    localparam int TMO   = 5000;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data, rd_en, clr_err;
    logic [7:0] key_reg;
    logic       key_valid, parity_err, frame_err, overflow;

    int total = 0;
    int bad   = 0;
    int half  = 15;
    int lat   = 0;
    logic [7:0] mq[$];
    logic e_perr = 1'b0, e_ferr = 1'b0, e_ovf = 1'b0;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .clr_err(clr_err), .key_reg(key_reg), .key_valid(key_valid),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [7:0] head();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    function automatic logic [10:0] mkframe(input logic [7:0] d, input logic badp, input logic stop);
        logic p;
        p = ((~^d) ^ badp);
        return {stop, p, d, 1'b0};
    endfunction

    task automatic model_frame(input logic [10:0] f);
        if ($countones(f[9:1]) % 2 != 1) e_perr = 1'b1;
        else if (!f[10])                 e_ferr = 1'b1;
        else if (mq.size() < DEPTH)      mq.push_back(f[8:1]);
        else                             e_ovf = 1'b1;
    endtask

    // mode 0: plain, 1: measure push latency on stop bit, 2: pulse rd_en in the push cycle
    task automatic send_bits(input logic [10:0] f, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            tick(half);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                int c;
                c = 0;
                while (!key_valid && c < 40) begin tick(1); c++; end
                lat = c;
                if (half > c) tick(half - c);
            end else if (i == 10 && mode == 2) begin
                if (lat > 1) tick(lat - 1);
                rd_en = 1'b1; tick(1); rd_en = 1'b0;
                tick(half - lat);
            end else begin
                tick(half);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(half);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic badp, input logic stop, input int mode);
        logic [10:0] f;
        f = mkframe(d, badp, stop);
        half = (mode == 2) ? 15 : int'($urandom_range(10, 20));
        send_bits(f, 11, mode);
        if (mode == 2 && mq.size() > 0) void'(mq.pop_front());
        model_frame(f);
    endtask

    task automatic do_pop();
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        e_perr = 1'b0; e_ferr = 1'b0; e_ovf = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        tick(3);
        total++; if (key_reg !== 8'h00) begin bad++; $display("FAIL reset_key actual=%h required=00", key_reg); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", key_valid); end
        total++; if ({parity_err, frame_err, overflow} !== 3'b000) begin bad++; $display("FAIL reset_flags actual=%b required=000", {parity_err, frame_err, overflow}); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_good_frame();
        send_byte(8'h1C, 1'b0, 1'b1, 1);
        total++; if (lat < 1 || lat > 12) begin bad++; $display("FAIL good_latency actual=%0d required=1..12", lat); end
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL good_valid actual=%b required=1", key_valid); end
        total++; if (key_reg !== 8'h1C) begin bad++; $display("FAIL good_key actual=%h required=1c", key_reg); end
        total++; if ({parity_err, frame_err} !== 2'b00) begin bad++; $display("FAIL good_errs actual=%b required=00", {parity_err, frame_err}); end
        do_pop();
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL pop_valid actual=%b required=0", key_valid); end
        total++; if (key_reg !== 8'h00) begin bad++; $display("FAIL pop_key actual=%h required=00", key_reg); end
    endtask

    task automatic test_bad_parity();
        send_byte(8'h1C, 1'b1, 1'b1, 0);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL par_valid actual=%b required=0", key_valid); end
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_flag actual=%b required=1", parity_err); end
        pulse_clr();
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clear actual=%b required=0", parity_err); end
        send_byte(8'hF0, 1'b0, 1'b1, 0);
        total++; if (key_reg !== 8'hF0) begin bad++; $display("FAIL par_next_key actual=%h required=f0", key_reg); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_next_flag actual=%b required=0", parity_err); end
        do_pop();
    endtask

    task automatic test_bad_stop();
        logic [7:0] d;
        d = 8'($urandom);
        send_byte(d, 1'b0, 1'b0, 0);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL stop_flag actual=%b required=1", frame_err); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL stop_valid actual=%b required=0", key_valid); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL stop_perr actual=%b required=0", parity_err); end
        pulse_clr();
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL stop_clear actual=%b required=0", frame_err); end
    endtask

    task automatic test_overflow();
        logic [7:0] v [5];
        v = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        for (int i = 0; i < 5; i++) send_byte(v[i], 1'b0, 1'b1, 0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag actual=%b required=1", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if (key_reg !== v[i] || key_valid !== 1'b1) begin bad++; $display("FAIL ovf_pop%0d actual=%h/%b required=%h/1", i, key_reg, key_valid, v[i]); end
            do_pop();
        end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty actual=%b required=0", key_valid); end
        pulse_clr();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear actual=%b required=0", overflow); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] v [4];
        v = '{8'h02, 8'h04, 8'h08, 8'h55};
        send_byte(8'h01, 1'b0, 1'b1, 0);
        send_byte(8'h02, 1'b0, 1'b1, 0);
        send_byte(8'h04, 1'b0, 1'b1, 0);
        send_byte(8'h08, 1'b0, 1'b1, 0);
        send_byte(8'h55, 1'b0, 1'b1, 2);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sim_ovf actual=%b required=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if (key_reg !== v[i] || key_valid !== 1'b1) begin bad++; $display("FAIL sim_pop%0d actual=%h/%b required=%h/1", i, key_reg, key_valid, v[i]); end
            do_pop();
        end
        total++; if (key_valid !== 1'b0 || key_reg !== 8'h00) begin bad++; $display("FAIL sim_empty actual=%b/%h required=0/00", key_valid, key_reg); end
    endtask

    task automatic test_timeout_glitch();
        int c;
        ps2_data = 1'b0;
        ps2_clk = 1'b0; tick(2); ps2_clk = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        tick(10);
        send_byte(8'h3A, 1'b0, 1'b1, 0);
        total++; if (key_reg !== 8'h3A || {parity_err, frame_err} !== 2'b00) begin bad++; $display("FAIL glitch_frame actual=%h/%b required=3a/00", key_reg, {parity_err, frame_err}); end
        do_pop();
        half = 15;
        send_bits(mkframe(8'hA5, 1'b0, 1'b1), 4, 0);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL tmo_early actual=%b required=0", frame_err); end
        c = 0;
        while (!frame_err && c < TMO + 1000) begin tick(1); c++; end
        c = c + 2 * half;
        total++; if (frame_err !== 1'b1 || c < TMO || c > TMO + 20) begin bad++; $display("FAIL tmo_flag actual=%b@%0d required=1@%0d..%0d", frame_err, c, TMO, TMO + 20); end
        pulse_clr();
        send_byte(8'h1C, 1'b0, 1'b1, 0);
        total++; if (key_reg !== 8'h1C || key_valid !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL tmo_next actual=%h/%b/%b required=1c/1/0", key_reg, key_valid, frame_err); end
        do_pop();
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) do_pop();
            if ($urandom_range(0, 4) == 0) pulse_clr();
            send_byte(d, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0), 0);
            total++; if (key_reg !== head() || key_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd%0d_fifo actual=%h/%b required=%h/%b", i, key_reg, key_valid, head(), mq.size() > 0); end
            total++; if ({parity_err, frame_err, overflow} !== {e_perr, e_ferr, e_ovf}) begin bad++; $display("FAIL rnd%0d_flags actual=%b required=%b", i, {parity_err, frame_err, overflow}, {e_perr, e_ferr, e_ovf}); end
        end
        while (mq.size() > 0) begin
            total++; if (key_reg !== head()) begin bad++; $display("FAIL rnd_drain actual=%h required=%h", key_reg, head()); end
            do_pop();
        end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rnd_empty actual=%b required=0", key_valid); end
        pulse_clr();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h77, 1'b0, 1'b1, 0);
        send_byte(8'h12, 1'b1, 1'b1, 0);
        half = 15;
        send_bits(mkframe(8'hC3, 1'b0, 1'b1), 6, 0);
        reset = 1'b1;
        #1;
        total++; if (key_reg !== 8'h00 || key_valid !== 1'b0) begin bad++; $display("FAIL rst_fifo actual=%h/%b required=00/0", key_reg, key_valid); end
        total++; if ({parity_err, frame_err, overflow} !== 3'b000) begin bad++; $display("FAIL rst_flags actual=%b required=000", {parity_err, frame_err, overflow}); end
        mq.delete(); e_perr = 1'b0; e_ferr = 1'b0; e_ovf = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
        send_byte(8'h29, 1'b0, 1'b1, 0);
        total++; if (key_reg !== 8'h29 || key_valid !== 1'b1) begin bad++; $display("FAIL rst_next actual=%h/%b required=29/1", key_reg, key_valid); end
        total++; if ({parity_err, frame_err} !== 2'b00) begin bad++; $display("FAIL rst_next_errs actual=%b required=00", {parity_err, frame_err}); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_bad_stop();
        test_overflow();
        test_simultaneous();
        test_timeout_glitch();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Upstream keyboard front-end for the multicycle processor.
- Receives PS/2 device-to-host frames and checks them.
- Buffers the scan codes in a small FIFO and presents the head byte as key_reg to the memory-mapped keyboard register.
- The processor's load of that register asserts rd_en to pop one byte.

Parameters:
FIFO_DEPTH, 4, scan-code FIFO entries; power of 2, minimum 2
FILTER_LEN, 4, consecutive equal clk samples required to accept a ps2_clk level change
TIMEOUT_CYCLES, 5000, idle clk cycles inside a frame before the frame is aborted

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous
ps2_data  input  1  raw PS/2 data from keyboard, asynchronous
rd_en  input  1  one-cycle pop request from the memory read path
clr_err  input  1  clears the sticky error flags
key_reg  output  8  FIFO head byte; 8'h00 when empty
key_valid  output  1  FIFO not empty
parity_err  output  1  sticky: a frame failed the odd-parity check
frame_err  output  1  sticky: bad stop bit or timeout
overflow  output  1  sticky: a good byte was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high):
  - All outputs are 0.
  - FSM goes to IDLE; FIFO is empty with pointers 0.
  - Filter state and synchronizers are set to 1 (bus idle high).
  - A reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - Filtered clk changes level only after FILTER_LEN consecutive synchronized samples of the new level.
  - fall = filtered clk 1->0, a one-cycle pulse.
  - Data is sampled (synchronized) in the cycle fall is high.
- FSM, advancing on fall only:
  - IDLE: data=0 -> DATA with bitcnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift right, new bit into bit 7 (LSB first). bitcnt increments; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP:
    - Odd parity over the 8 data bits plus the parity bit is required.
    - Stop bit must be 1.
    - Parity bad -> parity_err set; byte discarded.
    - Stop bit 0 (parity ok) -> frame_err set; byte discarded.
    - Both good -> push request.
    - Always -> IDLE.
- Timeout:
  - A counter runs in any non-IDLE state and resets on every fall.
  - When it reaches TIMEOUT_CYCLES -> IDLE, frame_err set, partial byte discarded.
- Latency:
  - The push is written at the clock edge that ends the stop-bit fall cycle.
  - key_valid and key_reg update in the next cycle.
- FIFO:
  - key_reg shows the head combinationally from registered storage; it is 8'h00 when empty.
  - rd_en while non-empty pops at the clock edge; rd_en while empty is ignored.
  - Push while full with no pop -> byte dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle -> both performed, count unchanged. This holds when full too: the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count is a separate register, width clog2(FIFO_DEPTH)+1.
- Sticky flags:
  - Cleared by clr_err at the next edge.
  - If clr_err coincides with a new error event, the flag ends up set.
  - The flags never block reception.

Test Plan:
- Good frame: send 0x1C (start 0, bits LSB-first, parity 0, stop 1), ~40 us per bit -> key_valid=1 and key_reg=0x1C one cycle after the stop fall; no errors. Pulse rd_en -> key_valid=0, key_reg=0x00.
- Bad parity: send 0x1C with parity 1 -> key_valid stays 0, parity_err=1. Pulse clr_err -> parity_err=0. Then send 0xF0 (parity 1) -> key_reg=0xF0.
- Overflow: send 0x01, 0x02, 0x04, 0x08, 0x10 with no rd_en -> overflow=1. Four pops return 0x01, 0x02, 0x04, 0x08, then key_valid=0.
- Simultaneous: FIFO full; assert rd_en in the cycle the fifth byte 0x55 is pushed -> no overflow, count stays 4. Pops yield 0x02, 0x04, 0x08, 0x55.
- Timeout and glitch:
  - Send start plus 3 data bits, then hold ps2_clk high -> after 5000 cycles frame_err=1, FSM IDLE. A following 0x1C frame is received correctly.
  - A 2-cycle low glitch on ps2_clk produces no fall and no state change.
- Reset mid-frame: assert reset after 5 data bits -> all outputs 0 immediately. Post-reset frame 0x29 is received as 0x29.
